// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared constants for the Hi/Lo multiply/divide unit: opcodes, divider FSM states and
// the value Lo takes on a divide by zero.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpMadd  = 3'd2,
        OpMsub  = 3'd3,
        OpDiv   = 3'd4,
        OpDivu  = 3'd5,
        OpMthi  = 3'd6,
        OpMtlo  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDivide = 2'd1,
        StFixup  = 2'd2
    } div_state_e;

    localparam int unsigned MaxWidth = 64;

    // Sliced down to the instance width where used.
    localparam logic [MaxWidth-1:0] DivZeroLo = '1;

    function automatic logic is_div_op(op_e op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between a requester and the Hi/Lo multiply/divide unit.
interface hilo_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
);
    logic             Start;
    logic [OPW-1:0]   Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic [WIDTH-1:0] ReadHi;
    logic [WIDTH-1:0] ReadLo;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    modport master (
        output Start, Op, OperandA, OperandB,
        input  ReadHi, ReadLo, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, Op, OperandA, OperandB,
        output ReadHi, ReadLo, Busy, Done, DivByZero
    );
endinterface

// File: rtl/hilo_muldiv_unit_seq_divider.sv
// Restoring divider, one quotient bit per cycle, with sign fixup of the magnitude result.
// done_o marks the FIXUP cycle in which quotient_o/remainder_o are final.
module seq_divider
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    div_state_e       state_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsor_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             quot_neg_q;
    logic             rem_neg_q;
    logic             dbz_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quot_step;

    assign mag_a = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign mag_b = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // The quotient register doubles as the dividend shift source.
    assign shifted   = {rem_q, quot_q[WIDTH-1]};
    assign ge        = shifted >= {1'b0, dsor_q};
    assign diff      = shifted[WIDTH-1:0] - dsor_q;
    assign rem_step  = ge ? diff : shifted[WIDTH-1:0];
    assign quot_step = {quot_q[WIDTH-2:0], ge};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            quot_q     <= '0;
            rem_q      <= '0;
            dsor_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        if (divisor_i == '0) begin
                            quot_q     <= DivZeroLo[WIDTH-1:0];
                            rem_q      <= dividend_i;
                            quot_neg_q <= 1'b0;
                            rem_neg_q  <= 1'b0;
                            dbz_q      <= 1'b1;
                            state_q    <= StFixup;
                        end else begin
                            quot_q     <= mag_a;
                            rem_q      <= '0;
                            dsor_q     <= mag_b;
                            quot_neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                            rem_neg_q  <= signed_i & dividend_i[WIDTH-1];
                            dbz_q      <= 1'b0;
                            state_q    <= StDivide;
                        end
                    end
                end
                StDivide: begin
                    rem_q  <= rem_step;
                    quot_q <= quot_step;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFixup;
                    end
                end
                StFixup: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = (state_q == StFixup);
    assign div_by_zero_o = dbz_q;
    assign quotient_o    = quot_neg_q ? -quot_q : quot_q;
    assign remainder_o   = rem_neg_q  ? -rem_q  : rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// MIPS-style Hi/Lo unit: single-cycle multiply, multiply-accumulate and moves, plus an
// iterative divider whose result is committed to Hi/Lo only at the end of FIXUP.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input logic               Clk,
    input logic               Rst_n,
    hilo_muldiv_unit_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [OPW-1:0]   op_raw;
    op_e              op;
    logic             accept;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic             div_dbz;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    logic [DW-1:0]    a_sx, b_sx, a_zx, b_zx;
    logic [DW-1:0]    prod_s, prod_u, hilo, hilo_add, hilo_sub;

    assign op_raw = bus.Op;
    assign op     = op_e'(op_raw[2:0]);
    assign accept = bus.Start && !div_busy;

    // Sign/zero extension to 2*WIDTH makes a plain modulo multiply give the right product.
    assign a_sx     = {{WIDTH{bus.OperandA[WIDTH-1]}}, bus.OperandA};
    assign b_sx     = {{WIDTH{bus.OperandB[WIDTH-1]}}, bus.OperandB};
    assign a_zx     = {{WIDTH{1'b0}}, bus.OperandA};
    assign b_zx     = {{WIDTH{1'b0}}, bus.OperandB};
    assign prod_s   = a_sx * b_sx;
    assign prod_u   = a_zx * b_zx;
    assign hilo     = {hi_q, lo_q};
    assign hilo_add = hilo + prod_s;
    assign hilo_sub = hilo - prod_s;

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        div_start = 1'b0;
        if (div_done) begin
            hi_d   = div_rem;
            lo_d   = div_quot;
            done_d = 1'b1;
            dbz_d  = div_dbz;
        end else if (accept) begin
            dbz_d = 1'b0;
            if (is_div_op(op)) begin
                div_start = 1'b1;
            end else begin
                done_d = 1'b1;
                unique case (op)
                    OpMult:  {hi_d, lo_d} = prod_s;
                    OpMultu: {hi_d, lo_d} = prod_u;
                    OpMadd:  {hi_d, lo_d} = hilo_add;
                    OpMsub:  {hi_d, lo_d} = hilo_sub;
                    OpMthi:  hi_d = bus.OperandA;
                    OpMtlo:  lo_d = bus.OperandA;
                    default: done_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    seq_divider #(
        .WIDTH (WIDTH)
    ) u_seq_divider (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .start_i       (div_start),
        .signed_i      (op == OpDiv),
        .dividend_i    (bus.OperandA),
        .divisor_i     (bus.OperandB),
        .busy_o        (div_busy),
        .done_o        (div_done),
        .div_by_zero_o (div_dbz),
        .quotient_o    (div_quot),
        .remainder_o   (div_rem)
    );

    assign bus.ReadHi    = hi_q;
    assign bus.ReadLo    = lo_q;
    assign bus.Busy      = div_busy;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(32), .OPW(3)) bus32 ();
    hilo_muldiv_unit_if #(.WIDTH(8),  .OPW(3)) bus8 ();

    hilo_muldiv_unit #(.WIDTH(32), .OPW(3)) u_dut32 (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus32)
    );

    hilo_muldiv_unit #(.WIDTH(8), .OPW(3)) u_dut8 (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic issue32(input op_e op, input logic [31:0] a, input logic [31:0] b);
        bus32.Start    = 1'b1;
        bus32.Op       = op;
        bus32.OperandA = a;
        bus32.OperandB = b;
        @(posedge clk);
        #1;
        bus32.Start = 1'b0;
    endtask

    task automatic issue8(input op_e op, input logic [7:0] a, input logic [7:0] b);
        bus8.Start    = 1'b1;
        bus8.Op       = op;
        bus8.OperandA = a;
        bus8.OperandB = b;
        @(posedge clk);
        #1;
        bus8.Start = 1'b0;
    endtask

    // Edges from now until Done is seen; -1 if it never arrives.
    task automatic wait_done(input bit narrow, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (narrow ? bus8.Done : bus32.Done) return;
        end
        n = -1;
    endtask

    task automatic test_reset;
        checks++;
        if (bus32.ReadHi !== 32'h0 || bus32.ReadLo !== 32'h0) begin
            errors++;
            $display("FAIL reset_hilo: got %h_%h want 0_0", bus32.ReadHi, bus32.ReadLo);
        end
        checks++;
        if ({bus32.Busy, bus32.Done, bus32.DivByZero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus32.Busy, bus32.Done, bus32.DivByZero});
        end
        checks++;
        if ({bus8.Busy, bus8.Done, bus8.ReadHi, bus8.ReadLo} !== 18'h0) begin
            errors++;
            $display("FAIL reset_w8: got %h want 0", {bus8.Busy, bus8.Done, bus8.ReadHi, bus8.ReadLo});
        end
    endtask

    task automatic test_mult;
        issue32(OpMult, 32'hFFFF_FFFF, 32'h2);
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'hFFFF_FFFF_FFFF_FFFE || bus32.Done !== 1'b1) begin
            errors++;
            $display("FAIL mult: got %h_%h done %b want ffffffff_fffffffe done 1",
                     bus32.ReadHi, bus32.ReadLo, bus32.Done);
        end
        checks++;
        if (bus32.Busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_busy: got %b want 0", bus32.Busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus32.Done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: got %b want 0", bus32.Done);
        end
        issue32(OpMultu, 32'hFFFF_FFFF, 32'h2);
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0001_FFFF_FFFE || bus32.Done !== 1'b1) begin
            errors++;
            $display("FAIL multu: got %h_%h done %b want 00000001_fffffffe done 1",
                     bus32.ReadHi, bus32.ReadLo, bus32.Done);
        end
    endtask

    task automatic test_madd_msub;
        issue32(OpMthi, 32'h0, 32'h0);
        issue32(OpMtlo, 32'hFFFF_FFFF, 32'h0);
        issue32(OpMadd, 32'h1, 32'h1);
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0001_0000_0000 || bus32.Done !== 1'b1) begin
            errors++;
            $display("FAIL madd: got %h_%h done %b want 00000001_00000000 done 1",
                     bus32.ReadHi, bus32.ReadLo, bus32.Done);
        end
        issue32(OpMsub, 32'h1, 32'h2);
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0000_FFFF_FFFE) begin
            errors++;
            $display("FAIL msub: got %h_%h want 00000000_fffffffe", bus32.ReadHi, bus32.ReadLo);
        end
        // Signed accumulate: (-1)*3 added
        issue32(OpMadd, 32'hFFFF_FFFF, 32'h3);
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0000_FFFF_FFFB) begin
            errors++;
            $display("FAIL madd_signed: got %h_%h want 00000000_fffffffb",
                     bus32.ReadHi, bus32.ReadLo);
        end
    endtask

    task automatic test_div_signed;
        int busy_cycles;
        int leak;
        issue32(OpMthi, 32'h11, 32'h0);
        issue32(OpMtlo, 32'h22, 32'h0);
        bus32.Start    = 1'b1;
        bus32.Op       = OpDiv;
        bus32.OperandA = 32'hFFFF_FFF9;
        bus32.OperandB = 32'h2;
        @(posedge clk);
        #1;
        // Start stays high with a different op for the whole busy window.
        bus32.Op       = OpMthi;
        bus32.OperandA = 32'hDEAD;
        busy_cycles = 0;
        leak = 0;
        for (int i = 0; i < 100 && bus32.Busy; i++) begin
            busy_cycles++;
            if (bus32.ReadHi !== 32'h11 || bus32.ReadLo !== 32'h22) leak++;
            @(posedge clk);
            #1;
        end
        bus32.Start = 1'b0;
        checks++;
        if (busy_cycles != 33) begin
            errors++;
            $display("FAIL div_busy_len: got %0d want 33", busy_cycles);
        end
        checks++;
        if (leak != 0) begin
            errors++;
            $display("FAIL div_no_partial: got %0d leaking cycles want 0", leak);
        end
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'hFFFF_FFFF_FFFF_FFFD || bus32.Done !== 1'b1) begin
            errors++;
            $display("FAIL div_result: got %h_%h done %b want ffffffff_fffffffd done 1",
                     bus32.ReadHi, bus32.ReadLo, bus32.Done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus32.Done !== 1'b0 || bus32.ReadHi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_after: got done %b hi %h want done 0 hi ffffffff",
                     bus32.Done, bus32.ReadHi);
        end
    endtask

    task automatic test_div_by_zero;
        int n;
        issue32(OpDivu, 32'd100, 32'h0);
        checks++;
        if (bus32.Busy !== 1'b1) begin
            errors++;
            $display("FAIL dbz_busy: got %b want 1", bus32.Busy);
        end
        wait_done(1'b0, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d want 1", n);
        end
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0064_FFFF_FFFF || bus32.DivByZero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: got %h_%h flag %b want 00000064_ffffffff flag 1",
                     bus32.ReadHi, bus32.ReadLo, bus32.DivByZero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus32.DivByZero !== 1'b1 || bus32.Done !== 1'b0) begin
            errors++;
            $display("FAIL dbz_hold: got flag %b done %b want flag 1 done 0",
                     bus32.DivByZero, bus32.Done);
        end
    endtask

    task automatic test_div_overflow;
        int n;
        issue32(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++;
        if (bus32.DivByZero !== 1'b0 || bus32.Busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_start: got flag %b busy %b want flag 0 busy 1",
                     bus32.DivByZero, bus32.Busy);
        end
        wait_done(1'b0, n);
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL ovf_latency: got %0d want 33", n);
        end
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0000_8000_0000 || bus32.DivByZero !== 1'b0) begin
            errors++;
            $display("FAIL ovf_result: got %h_%h flag %b want 00000000_80000000 flag 0",
                     bus32.ReadHi, bus32.ReadLo, bus32.DivByZero);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        bus32.Start    = 1'b1;
        bus32.Op       = OpMultu;
        bus32.OperandA = 32'd3;
        bus32.OperandB = 32'd5;
        @(posedge clk);
        #1;
        checks++;
        if (bus32.Done !== 1'b1 || bus32.ReadLo !== 32'd15) begin
            errors++;
            $display("FAIL b2b_multu: got done %b lo %h want done 1 lo f", bus32.Done, bus32.ReadLo);
        end
        bus32.Op       = OpMtlo;
        bus32.OperandA = 32'd7;
        @(posedge clk);
        #1;
        checks++;
        if (bus32.Done !== 1'b1 || {bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0000_0000_0007) begin
            errors++;
            $display("FAIL b2b_mtlo: got done %b %h_%h want done 1 0_7",
                     bus32.Done, bus32.ReadHi, bus32.ReadLo);
        end
        bus32.Op       = OpDivu;
        bus32.OperandA = 32'd20;
        bus32.OperandB = 32'd6;
        @(posedge clk);
        #1;
        bus32.Start = 1'b0;
        checks++;
        if (bus32.Busy !== 1'b1 || bus32.ReadLo !== 32'd7) begin
            errors++;
            $display("FAIL b2b_div_start: got busy %b lo %h want busy 1 lo 7", bus32.Busy, bus32.ReadLo);
        end
        wait_done(1'b0, n);
        checks++;
        if (n != 33 || {bus32.ReadHi, bus32.ReadLo} !== 64'h0000_0002_0000_0003) begin
            errors++;
            $display("FAIL b2b_divu: got n %0d %h_%h want n 33 2_3", n, bus32.ReadHi, bus32.ReadLo);
        end
    endtask

    task automatic test_reset_mid_divide;
        issue32(OpMtlo, 32'h55, 32'h0);
        issue32(OpDiv, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2;
        checks++;
        if (bus32.Busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: got %b want 1", bus32.Busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0 ||
            {bus32.Busy, bus32.Done, bus32.DivByZero} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_clear: got %h_%h flags %b want 0_0 flags 000",
                     bus32.ReadHi, bus32.ReadLo, {bus32.Busy, bus32.Done, bus32.DivByZero});
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue32(OpMthi, 32'h1234, 32'h0);
        checks++;
        if ({bus32.ReadHi, bus32.ReadLo} !== 64'h0000_1234_0000_0000 || bus32.Done !== 1'b1) begin
            errors++;
            $display("FAIL rst_mthi: got %h_%h done %b want 00001234_00000000 done 1",
                     bus32.ReadHi, bus32.ReadLo, bus32.Done);
        end
    endtask

    task automatic test_width8;
        int n;
        issue8(OpDivu, 8'd200, 8'd7);
        checks++;
        if (bus8.Busy !== 1'b1) begin
            errors++;
            $display("FAIL w8_busy: got %b want 1", bus8.Busy);
        end
        wait_done(1'b1, n);
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL w8_latency: got %0d want 9", n);
        end
        checks++;
        if (bus8.ReadLo !== 8'd28 || bus8.ReadHi !== 8'd4) begin
            errors++;
            $display("FAIL w8_divu: got hi %0d lo %0d want hi 4 lo 28", bus8.ReadHi, bus8.ReadLo);
        end
        issue8(OpMult, 8'hFD, 8'h05);
        checks++;
        if ({bus8.ReadHi, bus8.ReadLo} !== 16'hFFF1) begin
            errors++;
            $display("FAIL w8_mult: got %h_%h want ff_f1", bus8.ReadHi, bus8.ReadLo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        bus32.Start    = 1'b0;
        bus32.Op       = 3'd0;
        bus32.OperandA = '0;
        bus32.OperandB = '0;
        bus8.Start     = 1'b0;
        bus8.Op        = 3'd0;
        bus8.OperandA  = '0;
        bus8.OperandB  = '0;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_mult();
        test_madd_msub();
        test_div_signed();
        test_div_by_zero();
        test_div_overflow();
        test_back_to_back();
        test_reset_mid_divide();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and Hi/Lo register width; legal values 8 to 64, even.
REQ-002 SHALL have parameter OPW, default 3, opcode width.
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  launches Op this cycle when Busy is low.
REQ-006 SHALL have port Op  input  OPW  operation code, encoding per REQ-010.
REQ-007 SHALL have port OperandA  input  WIDTH  rs value (multiplicand/dividend/MTHI-MTLO source).
REQ-008 SHALL have port OperandB  input  WIDTH  rt value (multiplier/divisor).
REQ-009 SHALL have ports ReadHi  output  WIDTH, ReadLo  output  WIDTH, Busy  output  1, Done  output  1, DivByZero  output  1; all registered, no combinational path from inputs.

Function
REQ-010 SHALL decode Op: 0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO.
REQ-011 SHALL ignore Start while Busy is high; no state change, no error flag.
REQ-012 SHALL, for MULT/MULTU, write the 2*WIDTH product (signed/unsigned) to {Hi,Lo} one cycle after the Start edge; Done pulses high for exactly that cycle; Busy stays low.
REQ-013 SHALL, for MADD/MSUB, compute {Hi,Lo} +/- signed(A*B) modulo 2^(2*WIDTH), carry/borrow out discarded, same one-cycle latency and Done pulse.
REQ-014 SHALL, for MTHI/MTLO, write OperandA into Hi or Lo only, other register unchanged, one-cycle latency, Done pulses.
REQ-015 SHALL implement DIV/DIVU as restoring divider, one quotient bit per cycle, FSM states IDLE -> DIVIDE (WIDTH cycles) -> FIXUP (1 cycle) -> IDLE.
REQ-016 SHALL assert Busy from the cycle after the accepting Start edge through the FIXUP cycle inclusive (WIDTH+1 cycles); Done pulses in the first IDLE cycle after FIXUP, when Lo=quotient and Hi=remainder are visible.
REQ-017 SHALL, for DIV, divide magnitudes and negate quotient if operand signs differ; remainder takes the sign of the dividend (truncating division).
REQ-018 SHALL, for DIV of most-negative value by -1, return Lo = most-negative value, Hi = 0, no flag.
REQ-019 SHALL, on divide by zero (OperandB = 0), skip DIVIDE, go straight to FIXUP, set Lo = all ones, Hi = OperandA, and hold DivByZero high with Done; DivByZero clears on the next accepted Start.
REQ-020 SHALL keep ReadHi/ReadLo equal to committed Hi/Lo; intermediate divider state SHALL NOT appear on them until FIXUP commits.
REQ-021 SHALL accept a new Start in the same cycle Done is high (back-to-back issue).

Reset
REQ-022 SHALL, on Rst_n low, immediately clear Hi, Lo, Busy, Done, DivByZero, divider registers and cycle counter, and force FSM to IDLE, independent of Clk.
REQ-023 SHALL abort an in-flight divide on reset with no partial result committed; first Start after Rst_n rises is accepted normally.

Structure
REQ-024 SHALL place opcode constants (8 values), FSM state encoding and the divide-by-zero Lo constant in shared package muldiv_pkg.
REQ-025 SHALL isolate the iterative divider (shift/subtract datapath, counter, sign fixup) in sub-module seq_divider, with start/busy/done handshake.
REQ-026 SHALL size the cycle counter as clog2(WIDTH)+1 bits and derive all widths from WIDTH.

Verification
REQ-027 SHALL cover: WIDTH=32, MULT A=0xFFFFFFFF B=2 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFE, Done one cycle later; MULTU same -> Hi=0x00000001, Lo=0xFFFFFFFE.
REQ-028 SHALL cover: Hi:Lo=0x00000000_FFFFFFFF, MADD A=1 B=1 -> Hi=1, Lo=0; then MSUB A=1 B=2 -> Hi=0, Lo=0xFFFFFFFE.
REQ-029 SHALL cover: DIV A=-7 B=2 -> Lo=-3, Hi=-1, Busy high exactly 33 cycles, Done on cycle 34; Start held during Busy ignored.
REQ-030 SHALL cover: DIVU A=100 B=0 -> Lo=0xFFFFFFFF, Hi=100, DivByZero=1; DIV 0x80000000 by -1 -> Lo=0x80000000, Hi=0.
REQ-031 SHALL cover: Rst_n asserted mid-divide at cycle 10, off-edge -> all outputs zero immediately; following MTHI A=0x1234 -> ReadHi=0x1234, ReadLo=0.
REQ-032 SHALL cover: WIDTH=8 DIVU 200/7 -> Lo=28, Hi=4, Busy 9 cycles.
